// File: rtl/conv_allocator_if.sv
// Bus bundle of one allocator: broadcast pixel stream, weight memory read port
// and the result valid/ready handshake.
interface conv_allocator_if #(
    parameter int ACC_W  = 48,
    parameter int TAP_W  = 14,
    parameter int DATA_W = 18,
    parameter int COEF_W = 18
);
    logic        [7:0]        issue_x;
    logic        [7:0]        issue_y;
    logic signed [DATA_W-1:0] issue_data;
    logic                     issue_en;
    logic                     issue_block;
    logic        [TAP_W-1:0]  weight_addr;
    logic signed [COEF_W-1:0] weight_data;
    logic signed [ACC_W-1:0]  result_data;
    logic        [7:0]        result_x;
    logic        [7:0]        result_y;
    logic                     result_valid;
    logic                     result_ready;

    modport slave (
        input  issue_x, issue_y, issue_data, issue_en, weight_data, result_ready,
        output issue_block, weight_addr, result_data, result_x, result_y, result_valid
    );

    modport master (
        output issue_x, issue_y, issue_data, issue_en, weight_data, result_ready,
        input  issue_block, weight_addr, result_data, result_x, result_y, result_valid
    );
endinterface

// File: rtl/conv_allocator.sv
// One convolution DSP slot: latches a filter centre, picks its window out of the
// broadcast pixel stream, multiply-accumulates against fetched weights, emits one result.
module conv_allocator #(
    parameter int ACC_W  = 48,
    parameter int TAP_W  = 14,
    parameter int DATA_W = 18,
    parameter int COEF_W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          position_x,
    input  logic [7:0]          position_y,
    input  logic                position_select,
    input  logic [1:0]          filter_halfsize,
    input  logic [8:0]          z_max,
    conv_allocator_if.slave     bus,
    output logic                overrun
);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic        [7:0]         cx_q, cx_d, cy_q, cy_d;
    logic        [1:0]         h_q, h_d;
    logic        [TAP_W-1:0]   total_q, total_d;
    logic        [TAP_W-1:0]   tap_q, tap_d;
    logic        [TAP_W-1:0]   weight_addr_q, weight_addr_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   result_data_q, result_data_d;
    logic        [7:0]         result_x_q, result_x_d, result_y_q, result_y_d;
    logic                      result_valid_q, result_valid_d;
    logic                      issue_block_q, issue_block_d;
    logic                      overrun_q, overrun_d;
    logic                      drain_q, drain_d;
    logic                      vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic signed [DATA_W-1:0]  pix_p1_q, pix_p1_d, pix_p2_q, pix_p2_d;

    logic                      hit;
    logic                      start;
    logic        [8:0]         h9;
    logic        [2:0]         side;
    logic        [5:0]         area;

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [COEF_W-1:0] b
    );
        logic signed [DATA_W+COEF_W-1:0] prod;
        logic signed [ACC_W-1:0]         prod_ext;
        prod     = (DATA_W+COEF_W)'(a) * (DATA_W+COEF_W)'(b);
        prod_ext = ACC_W'(prod);
        return acc + prod_ext;
    endfunction

    // Window test in 9 bits so a centre near 0 or 255 never wraps.
    always_comb begin
        h9  = {7'd0, h_q};
        hit = bus.issue_en
            && (({1'b0, bus.issue_x} + h9) >= {1'b0, cx_q})
            && ({1'b0, bus.issue_x} <= ({1'b0, cx_q} + h9))
            && (({1'b0, bus.issue_y} + h9) >= {1'b0, cy_q})
            && ({1'b0, bus.issue_y} <= ({1'b0, cy_q} + h9));
    end

    always_comb begin
        state_d        = state_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
        h_d            = h_q;
        total_d        = total_q;
        tap_d          = tap_q;
        weight_addr_d  = weight_addr_q;
        result_data_d  = result_data_q;
        result_x_d     = result_x_q;
        result_y_d     = result_y_q;
        result_valid_d = result_valid_q;
        issue_block_d  = issue_block_q;
        overrun_d      = overrun_q;
        drain_d        = drain_q;
        start          = 1'b0;
        side           = {filter_halfsize, 1'b1};
        area           = 6'(side) * 6'(side);

        // p1: hit registered with its pixel; p2: pixel waits for the weight word.
        vld_p1_d = 1'b0;
        pix_p1_d = bus.issue_data;
        vld_p2_d = vld_p1_q;
        pix_p2_d = pix_p1_q;
        acc_d    = vld_p2_q ? mac(acc_q, pix_p2_q, bus.weight_data) : acc_q;

        unique case (state_q)
            IDLE: begin
                if (position_select) start = 1'b1;
            end
            ARMED: begin
                if (position_select) begin
                    start = 1'b1;
                end else if (hit) begin
                    weight_addr_d = tap_q;
                    tap_d         = tap_q + TAP_W'(1);
                    vld_p1_d      = 1'b1;
                    if (tap_d == total_q) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (position_select) begin
                    start = 1'b1;
                end else if (drain_q) begin
                    // Last product lands on this edge, so take the updated sum.
                    result_data_d  = acc_d;
                    result_x_d     = cx_q;
                    result_y_d     = cy_q;
                    result_valid_d = 1'b1;
                    issue_block_d  = 1'b1;
                    state_d        = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                if (result_valid_q && bus.result_ready) begin
                    result_valid_d = 1'b0;
                    issue_block_d  = 1'b0;
                    state_d        = IDLE;
                    if (position_select) start = 1'b1;
                end else if (position_select) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new round discards anything still in the product pipeline.
        if (start) begin
            cx_d     = position_x;
            cy_d     = position_y;
            h_d      = filter_halfsize;
            total_d  = TAP_W'(area) * (TAP_W'(z_max) + TAP_W'(1));
            tap_d    = '0;
            acc_d    = '0;
            vld_p1_d = 1'b0;
            vld_p2_d = 1'b0;
            drain_d  = 1'b0;
            state_d  = ARMED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tap_q          <= '0;
            weight_addr_q  <= '0;
            acc_q          <= '0;
            result_data_q  <= '0;
            result_x_q     <= '0;
            result_y_q     <= '0;
            result_valid_q <= 1'b0;
            issue_block_q  <= 1'b0;
            overrun_q      <= 1'b0;
            drain_q        <= 1'b0;
            vld_p1_q       <= 1'b0;
            vld_p2_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            weight_addr_q  <= weight_addr_d;
            acc_q          <= acc_d;
            result_data_q  <= result_data_d;
            result_x_q     <= result_x_d;
            result_y_q     <= result_y_d;
            result_valid_q <= result_valid_d;
            issue_block_q  <= issue_block_d;
            overrun_q      <= overrun_d;
            drain_q        <= drain_d;
            vld_p1_q       <= vld_p1_d;
            vld_p2_q       <= vld_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        cx_q     <= cx_d;
        cy_q     <= cy_d;
        h_q      <= h_d;
        total_q  <= total_d;
        pix_p1_q <= pix_p1_d;
        pix_p2_q <= pix_p2_d;
    end

    assign bus.issue_block  = issue_block_q;
    assign bus.weight_addr  = weight_addr_q;
    assign bus.result_data  = result_data_q;
    assign bus.result_x     = result_x_q;
    assign bus.result_y     = result_y_q;
    assign bus.result_valid = result_valid_q;
    assign overrun          = overrun_q;

endmodule

// File: doc/conv_allocator.md
Name: conv_allocator

Overview:
- One allocator (DSP slot) sitting directly downstream of the issue stage; one instance per DSP, num_allocators instances in parallel.
- Latches a filter-centre position from the positioner.
- Watches the broadcast pixel stream and selects the beats inside its filter window.
- Fetches the matching filter weight, multiply-accumulates, and presents one convolution result per round on a valid/ready output.
- Asserts its block line while holding an unconsumed result.

Parameters:
- ACC_W, 48, accumulator and result width; must be >= 36.
- TAP_W, 14, tap counter and weight address width; covers 5*5*384 = 9600 taps.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- position_x  in  8  filter centre x, padded coordinates
- position_y  in  8  filter centre y, padded coordinates
- position_select  in  1  one-cycle strobe; latch position_x/y
- filter_halfsize  in  2  h; window is (2h+1)x(2h+1); static during a round
- z_max  in  9  image_depth-1; static during a round
- issue_x  in  8  broadcast pixel x
- issue_y  in  8  broadcast pixel y
- issue_data  in  18  broadcast pixel value, signed
- issue_en  in  1  broadcast beat valid
- issue_block  out  1  hold broadcast
- weight_addr  out  TAP_W  weight memory read address
- weight_data  in  18  signed weight; valid 1 cycle after weight_addr
- result_data  out  ACC_W  signed accumulated result
- result_x  out  8  latched centre x accompanying the result
- result_y  out  8  latched centre y accompanying the result
- result_valid  out  1  result present
- result_ready  in  1  consumer accepts result
- overrun  out  1  sticky: select arrived while a result was still unconsumed

Behaviour:
- Reset (async) values:
  - state = IDLE
  - issue_block, result_valid, overrun = 0
  - result_data, result_x, result_y, weight_addr = 0
  - accumulator and tap counter = 0
- States: IDLE, ARMED, DRAIN, DONE.
- IDLE:
  - position_select -> latch cx/cy, clear accumulator and tap counter, go to ARMED.
  - Broadcast beats are ignored.
- ARMED:
  - Window hit = issue_en && issue_x+h >= cx && issue_x <= cx+h && same test on y. All compares use 9-bit unsigned arithmetic, so there is no wrap at 0 or 255.
  - Each hit is one tap: weight_addr <= tap counter, data registered (cycle +1); product formed and added when weight_data arrives (cycle +2).
  - Tap counter increments per hit.
  - Pipeline latency from hit to accumulator update = 2 cycles; back-to-back hits are supported at 1 per cycle.
  - Tap order equals broadcast order; the weight memory is loaded in that same order.
  - Total taps T = (2h+1)^2 * (z_max+1), computed at latch time.
  - When the hit making the counter reach T is accepted -> DRAIN.
- DRAIN:
  - Wait 2 cycles for the pipeline to empty.
  - Then result_data <= accumulator, result_x/y <= cx/cy, result_valid <= 1, issue_block <= 1, go to DONE.
- DONE:
  - Outputs held stable while result_valid && !result_ready.
  - When result_valid && result_ready at a clock edge: result_valid <= 0, issue_block <= 0, go to IDLE.
- Arithmetic:
  - 18x18 signed product gives 36 bits, sign-extended to ACC_W.
  - Accumulator wraps modulo 2^ACC_W; there is no saturation.
- position_select in ARMED or DRAIN: abandon current round, discard in-flight products, clear accumulator/counter, latch new position, go to ARMED.
- position_select in DONE: ignored; overrun <= 1 (cleared only by rst).
- position_select in the same cycle as a DONE handshake: handshake completes, select latches, next state ARMED, overrun stays 0.
- Hits in IDLE/DRAIN/DONE are ignored.
- h = 0 is legal: single-pixel window, T = z_max+1.
- rst asserted mid-round: immediate return to reset values, with no result emitted.

Test Plan:
- h=1, z_max=0, select at (10,10); broadcast full 8..12 square of (x,y), data=1, weight=2 -> exactly 9 weight reads (addr 0..8); result_valid 2 cycles after last hit; result_data=18, result_x/y=10/10, issue_block=1.
- Same as the first test with result_ready held 0 for 5 cycles, then pulsed -> result and block stable for all 5 cycles; both drop on the cycle after the handshake edge; state returns to IDLE.
- Edge window: h=2, centre (1,1), pixel at x=255 -> no hit (no wrap); pixels x,y in 0..3 -> hits; T=25 with z_max=0.
- Signed/depth: h=0, z_max=2, data {-3,4,-5}, weights {7,-1,2} -> result_data = -35 (sign-extended to 48 bits).
- Re-select at tap 4 of 9 -> accumulator cleared, weight_addr restarts at 0, only the new round's result is emitted; select during DONE -> overrun=1, result unchanged.
- rst pulsed asynchronously between clock edges mid-ARMED -> all outputs 0 immediately; subsequent select works normally.
